// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: shared widths, constants and slot state encoding for the dispatcher
package dispatcher_pkg;
  localparam int DATA_LEN_DEF   = 32;
  localparam int ADDR_LEN_DEF   = 32;
  localparam int ROB_LEN_DEF    = 4;
  localparam int OPENUM_LEN_DEF = 6;
  localparam int REG_LEN_DEF    = 5;
  localparam logic [OPENUM_LEN_DEF-1:0] OPENUM_NOP = '0;
  localparam logic [ROB_LEN_DEF:0] ZERO_ROB = '0;
  localparam logic [DATA_LEN_DEF-1:0] ZERO_WORD = '0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic {EMPTY, HELD} slot_state_t;
endpackage

// File: rtl/dispatcher_operand_resolver.sv
// dispatcher_operand_resolver: turns a register V/Q pair into a value or producer tag
// Ports: reg_v/reg_q register file view; rob_ready/rob_value producer status in ROB;
// cdb_valid/cdb_tag/cdb_result broadcast; v/q resolved operand (q = 0 means v is valid).
// Tying rob_ready low leaves only the CDB path, which serves snoop and bypass.
module dispatcher_operand_resolver
  import dispatcher_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int TAG_LEN  = ROB_LEN_DEF + 1
) (
  input  logic [DATA_LEN-1:0] reg_v,
  input  logic [TAG_LEN-1:0]  reg_q,
  input  logic                rob_ready,
  input  logic [DATA_LEN-1:0] rob_value,
  input  logic                cdb_valid,
  input  logic [TAG_LEN-1:0]  cdb_tag,
  input  logic [DATA_LEN-1:0] cdb_result,
  output logic [DATA_LEN-1:0] v,
  output logic [TAG_LEN-1:0]  q
);
  logic no_dep, cdb_hit;
  assign no_dep  = reg_q == '0;
  assign cdb_hit = cdb_valid && cdb_tag == reg_q;
  assign v = no_dep ? reg_v : cdb_hit ? cdb_result : rob_ready ? rob_value : '0;
  assign q = (no_dep || cdb_hit || rob_ready) ? '0 : reg_q;
endmodule

// File: rtl/dispatcher.sv
// dispatcher: issue stage; allocates ROB tag, renames rd, resolves operands, holds one slot for RS/LSB
// Ports: clk/rst (async active-low); decoder fields + ready_to_dec; register file V/Q and rename;
// ROB tag/full/ready/value, alloc and rollback; CDB broadcast; RS/LSB full, insert strobes and payload.
module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int ADDR_LEN   = ADDR_LEN_DEF,
  parameter int ROB_LEN    = ROB_LEN_DEF,
  parameter int OPENUM_LEN = OPENUM_LEN_DEF,
  parameter int REG_LEN    = REG_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_from_dec,
  input  logic [OPENUM_LEN-1:0] openum_from_dec,
  input  logic [REG_LEN-1:0]    rd_from_dec,
  input  logic [REG_LEN-1:0]    rs1_from_dec,
  input  logic [REG_LEN-1:0]    rs2_from_dec,
  input  logic [DATA_LEN-1:0]   imm_from_dec,
  input  logic [ADDR_LEN-1:0]   pc_from_dec,
  input  logic                  is_ls_from_dec,
  output logic                  ready_to_dec,
  input  logic [ROB_LEN:0]      Q1_from_reg,
  input  logic [ROB_LEN:0]      Q2_from_reg,
  input  logic [DATA_LEN-1:0]   V1_from_reg,
  input  logic [DATA_LEN-1:0]   V2_from_reg,
  output logic                  rename_ena_to_reg,
  output logic [REG_LEN-1:0]    rename_rd_to_reg,
  output logic [ROB_LEN:0]      rename_tag_to_reg,
  input  logic [ROB_LEN:0]      rob_tag_from_rob,
  input  logic                  rob_full_from_rob,
  input  logic                  Q1_ready_from_rob,
  input  logic                  Q2_ready_from_rob,
  input  logic [DATA_LEN-1:0]   Q1_value_from_rob,
  input  logic [DATA_LEN-1:0]   Q2_value_from_rob,
  output logic                  alloc_to_rob,
  input  logic                  rollback_from_rob,
  input  logic                  valid_from_cdb,
  input  logic [ROB_LEN:0]      rob_id_from_cdb,
  input  logic [DATA_LEN-1:0]   result_from_cdb,
  input  logic                  rs_full_from_rs,
  input  logic                  lsb_full_from_lsb,
  output logic                  ena_to_rs,
  output logic                  ena_to_lsb,
  output logic [OPENUM_LEN-1:0] openum_to_ex,
  output logic [DATA_LEN-1:0]   V1_to_ex,
  output logic [DATA_LEN-1:0]   V2_to_ex,
  output logic [ROB_LEN:0]      Q1_to_ex,
  output logic [ROB_LEN:0]      Q2_to_ex,
  output logic [ADDR_LEN-1:0]   pc_to_ex,
  output logic [DATA_LEN-1:0]   imm_to_ex,
  output logic [ROB_LEN:0]      rob_id_to_ex
);
  localparam int TAG_LEN = ROB_LEN + 1;
  slot_state_t state, state_nx;
  logic                  slot_is_ls;
  logic [OPENUM_LEN-1:0] slot_op;
  logic [DATA_LEN-1:0]   slot_v1, slot_v2, slot_imm;
  logic [TAG_LEN-1:0]    slot_q1, slot_q2, slot_rob;
  logic [ADDR_LEN-1:0]   slot_pc;
  logic [DATA_LEN-1:0]   acc_v1, acc_v2, byp_v1, byp_v2;
  logic [TAG_LEN-1:0]    acc_q1, acc_q2, byp_q1, byp_q2;
  logic go, accept;
  logic unused;
  // Source register indices are consumed by the register file, not here.
  assign unused = ^{rs1_from_dec, rs2_from_dec};
  dispatcher_operand_resolver #(.DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN)) u_acc1 (
    .reg_v(V1_from_reg), .reg_q(Q1_from_reg), .rob_ready(Q1_ready_from_rob), .rob_value(Q1_value_from_rob),
    .cdb_valid(valid_from_cdb), .cdb_tag(rob_id_from_cdb), .cdb_result(result_from_cdb), .v(acc_v1), .q(acc_q1));
  dispatcher_operand_resolver #(.DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN)) u_acc2 (
    .reg_v(V2_from_reg), .reg_q(Q2_from_reg), .rob_ready(Q2_ready_from_rob), .rob_value(Q2_value_from_rob),
    .cdb_valid(valid_from_cdb), .cdb_tag(rob_id_from_cdb), .cdb_result(result_from_cdb), .v(acc_v2), .q(acc_q2));
  // Held operands only see the CDB: these outputs are both the snoop update and the payload bypass.
  dispatcher_operand_resolver #(.DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN)) u_byp1 (
    .reg_v(slot_v1), .reg_q(slot_q1), .rob_ready(1'b0), .rob_value('0),
    .cdb_valid(valid_from_cdb), .cdb_tag(rob_id_from_cdb), .cdb_result(result_from_cdb), .v(byp_v1), .q(byp_q1));
  dispatcher_operand_resolver #(.DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN)) u_byp2 (
    .reg_v(slot_v2), .reg_q(slot_q2), .rob_ready(1'b0), .rob_value('0),
    .cdb_valid(valid_from_cdb), .cdb_tag(rob_id_from_cdb), .cdb_result(result_from_cdb), .v(byp_v2), .q(byp_q2));
  always_comb begin
    go = state == HELD && !(slot_is_ls ? lsb_full_from_lsb : rs_full_from_rs) && !rollback_from_rob;
    accept = rst && valid_from_dec && !rob_full_from_rob && !rollback_from_rob && (state == EMPTY || go);
    state_nx = rollback_from_rob ? EMPTY : accept ? HELD : go ? EMPTY : state;
  end
  assign ready_to_dec      = accept;
  assign alloc_to_rob      = accept;
  assign rename_ena_to_reg = accept && rd_from_dec != '0;
  assign rename_rd_to_reg  = rd_from_dec;
  assign rename_tag_to_reg = rob_tag_from_rob;
  assign ena_to_rs         = go && !slot_is_ls;
  assign ena_to_lsb        = go && slot_is_ls;
  assign openum_to_ex      = slot_op;
  assign V1_to_ex          = byp_v1;
  assign V2_to_ex          = byp_v2;
  assign Q1_to_ex          = byp_q1;
  assign Q2_to_ex          = byp_q2;
  assign pc_to_ex          = slot_pc;
  assign imm_to_ex         = slot_imm;
  assign rob_id_to_ex      = slot_rob;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      slot_is_ls <= 1'b0;
      slot_op    <= OPENUM_LEN'(OPENUM_NOP);
      slot_v1    <= '0;
      slot_v2    <= '0;
      slot_q1    <= '0;
      slot_q2    <= '0;
      slot_pc    <= '0;
      slot_imm   <= '0;
      slot_rob   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        slot_is_ls <= is_ls_from_dec;
        slot_op    <= openum_from_dec;
        slot_v1    <= acc_v1;
        slot_v2    <= acc_v2;
        slot_q1    <= acc_q1;
        slot_q2    <= acc_q2;
        slot_pc    <= pc_from_dec;
        slot_imm   <= imm_from_dec;
        slot_rob   <= rob_tag_from_rob;
      end else begin
        slot_v1 <= byp_v1;
        slot_v2 <= byp_v2;
        slot_q1 <= byp_q1;
        slot_q2 <= byp_q2;
      end
    end
  end
endmodule

// File: tb/tb_dispatcher.sv
// tb_dispatcher: randomized and directed check of dispatcher against an instruction-level model
module tb_dispatcher;
  typedef struct {
    bit valid; logic [5:0] op; logic [4:0] rd; logic [31:0] imm, pc; bit is_ls;
    logic [4:0] q1, q2; logic [31:0] v1, v2;
    logic [4:0] rob_tag; bit rob_full, r1, r2; logic [31:0] rv1, rv2;
    bit rb; bit cv; logic [4:0] ctag; logic [31:0] cres;
    bit rs_full, lsb_full;
  } in_t;
  logic clk = 0, rst = 0;
  logic valid_from_dec, is_ls_from_dec, ready_to_dec;
  logic [5:0] openum_from_dec, openum_to_ex;
  logic [4:0] rd_from_dec, rs1_from_dec, rs2_from_dec, rename_rd_to_reg;
  logic [31:0] imm_from_dec, pc_from_dec, V1_from_reg, V2_from_reg, Q1_value_from_rob, Q2_value_from_rob;
  logic [4:0] Q1_from_reg, Q2_from_reg, rename_tag_to_reg, rob_tag_from_rob, rob_id_from_cdb;
  logic rename_ena_to_reg, rob_full_from_rob, Q1_ready_from_rob, Q2_ready_from_rob, alloc_to_rob, rollback_from_rob;
  logic valid_from_cdb, rs_full_from_rs, lsb_full_from_lsb, ena_to_rs, ena_to_lsb;
  logic [31:0] result_from_cdb, V1_to_ex, V2_to_ex, pc_to_ex, imm_to_ex;
  logic [4:0] Q1_to_ex, Q2_to_ex, rob_id_to_ex;
  int n_tests = 0, n_fail = 0;
  // model: at most one instruction waiting to be issued
  bit m_held, m_is_ls;
  logic [5:0] m_op; logic [31:0] m_pc, m_imm; logic [4:0] m_tag;
  logic [31:0] m_v [2]; logic [4:0] m_q [2];

  dispatcher dut (
    .clk(clk), .rst(rst),
    .valid_from_dec(valid_from_dec), .openum_from_dec(openum_from_dec), .rd_from_dec(rd_from_dec),
    .rs1_from_dec(rs1_from_dec), .rs2_from_dec(rs2_from_dec), .imm_from_dec(imm_from_dec),
    .pc_from_dec(pc_from_dec), .is_ls_from_dec(is_ls_from_dec), .ready_to_dec(ready_to_dec),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg), .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .rename_ena_to_reg(rename_ena_to_reg), .rename_rd_to_reg(rename_rd_to_reg), .rename_tag_to_reg(rename_tag_to_reg),
    .rob_tag_from_rob(rob_tag_from_rob), .rob_full_from_rob(rob_full_from_rob),
    .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
    .Q1_value_from_rob(Q1_value_from_rob), .Q2_value_from_rob(Q2_value_from_rob),
    .alloc_to_rob(alloc_to_rob), .rollback_from_rob(rollback_from_rob),
    .valid_from_cdb(valid_from_cdb), .rob_id_from_cdb(rob_id_from_cdb), .result_from_cdb(result_from_cdb),
    .rs_full_from_rs(rs_full_from_rs), .lsb_full_from_lsb(lsb_full_from_lsb),
    .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb), .openum_to_ex(openum_to_ex),
    .V1_to_ex(V1_to_ex), .V2_to_ex(V2_to_ex), .Q1_to_ex(Q1_to_ex), .Q2_to_ex(Q2_to_ex),
    .pc_to_ex(pc_to_ex), .imm_to_ex(imm_to_ex), .rob_id_to_ex(rob_id_to_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t s;
    s = '{default: 0};
    s.rob_tag = 5'd1;
    return s;
  endfunction

  function automatic in_t rnd_in();
    in_t s;
    s.valid = $urandom_range(0, 3) != 0;
    s.op = 6'($urandom_range(1, 63));
    s.rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
    s.imm = $urandom; s.pc = $urandom; s.is_ls = $urandom_range(0, 2) == 0;
    s.q1 = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 7));
    s.q2 = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 7));
    s.v1 = $urandom; s.v2 = $urandom;
    s.rob_tag = 5'($urandom_range(1, 31));
    s.rob_full = $urandom_range(0, 7) == 0;
    s.r1 = $urandom_range(0, 2) == 0; s.r2 = $urandom_range(0, 2) == 0;
    s.rv1 = $urandom; s.rv2 = $urandom;
    s.rb = $urandom_range(0, 15) == 0;
    s.cv = $urandom_range(0, 1); s.ctag = 5'($urandom_range(1, 7)); s.cres = $urandom;
    s.rs_full = $urandom_range(0, 1); s.lsb_full = $urandom_range(0, 1);
    return s;
  endfunction

  task automatic apply(input in_t s);
    valid_from_dec = s.valid; openum_from_dec = s.op; rd_from_dec = s.rd;
    rs1_from_dec = 5'($urandom); rs2_from_dec = 5'($urandom);
    imm_from_dec = s.imm; pc_from_dec = s.pc; is_ls_from_dec = s.is_ls;
    Q1_from_reg = s.q1; Q2_from_reg = s.q2; V1_from_reg = s.v1; V2_from_reg = s.v2;
    rob_tag_from_rob = s.rob_tag; rob_full_from_rob = s.rob_full;
    Q1_ready_from_rob = s.r1; Q2_ready_from_rob = s.r2;
    Q1_value_from_rob = s.rv1; Q2_value_from_rob = s.rv2;
    rollback_from_rob = s.rb; valid_from_cdb = s.cv; rob_id_from_cdb = s.ctag; result_from_cdb = s.cres;
    rs_full_from_rs = s.rs_full; lsb_full_from_lsb = s.lsb_full;
  endtask

  // A source becomes a value if the register already has it, the CDB delivers it now, or the ROB holds it.
  task automatic resolve(input logic [4:0] q, input logic [31:0] v, input bit rdy, input logic [31:0] rv,
                         input in_t s, output logic [31:0] ov, output logic [4:0] oq);
    if (q == 0) begin ov = v; oq = 0; end
    else if (s.cv && s.ctag == q) begin ov = s.cres; oq = 0; end
    else if (rdy) begin ov = rv; oq = 0; end
    else begin ov = 0; oq = q; end
  endtask

  function automatic bit wakes(input in_t s, input logic [4:0] q);
    return q != 0 && s.cv && s.ctag == q;
  endfunction

  // One cycle: drive at posedge+1, check mid-cycle, then advance the model across the edge.
  task automatic step(input in_t s);
    bit go, acc;
    logic [31:0] nv; logic [4:0] nq;
    apply(s);
    #4;
    go  = m_held && !(m_is_ls ? s.lsb_full : s.rs_full) && !s.rb;
    acc = s.valid && !s.rob_full && !s.rb && (!m_held || go);
    check("ready", ready_to_dec, acc);
    check("alloc", alloc_to_rob, acc);
    check("rename_ena", rename_ena_to_reg, acc && s.rd != 0);
    if (acc && s.rd != 0) begin
      check("rename_rd", rename_rd_to_reg, s.rd);
      check("rename_tag", rename_tag_to_reg, s.rob_tag);
    end
    check("ena_rs", ena_to_rs, go && !m_is_ls);
    check("ena_lsb", ena_to_lsb, go && m_is_ls);
    if (go) begin
      check("openum", openum_to_ex, m_op);
      check("pc", pc_to_ex, m_pc);
      check("imm", imm_to_ex, m_imm);
      check("rob_id", rob_id_to_ex, m_tag);
      check("V1", V1_to_ex, wakes(s, m_q[0]) ? s.cres : m_v[0]);
      check("Q1", Q1_to_ex, wakes(s, m_q[0]) ? 5'd0 : m_q[0]);
      check("V2", V2_to_ex, wakes(s, m_q[1]) ? s.cres : m_v[1]);
      check("Q2", Q2_to_ex, wakes(s, m_q[1]) ? 5'd0 : m_q[1]);
    end
    @(posedge clk);
    if (s.rb) m_held = 0;
    else if (acc) begin
      m_held = 1; m_is_ls = s.is_ls; m_op = s.op; m_pc = s.pc; m_imm = s.imm; m_tag = s.rob_tag;
      resolve(s.q1, s.v1, s.r1, s.rv1, s, nv, nq); m_v[0] = nv; m_q[0] = nq;
      resolve(s.q2, s.v2, s.r2, s.rv2, s, nv, nq); m_v[1] = nv; m_q[1] = nq;
    end else if (go) m_held = 0;
    else for (int i = 0; i < 2; i++) if (wakes(s, m_q[i])) begin m_v[i] = s.cres; m_q[i] = 0; end
    #1;
  endtask

  task automatic reset_checks();
    check("rst_ready", ready_to_dec, 0);
    check("rst_alloc", alloc_to_rob, 0);
    check("rst_rename", rename_ena_to_reg, 0);
    check("rst_ena", {ena_to_rs, ena_to_lsb}, 0);
    check("rst_payload", {openum_to_ex, V1_to_ex, Q1_to_ex, Q2_to_ex, rob_id_to_ex}, 0);
    check("rst_payload2", {V2_to_ex, pc_to_ex}, 0);
    check("rst_imm", imm_to_ex, 0);
  endtask

  // Asynchronous reset dropped mid-cycle while inputs still request work.
  task automatic reset_mid(input in_t s);
    apply(s);
    rst = 0;
    #2;
    reset_checks();
    m_held = 0;
    @(posedge clk);
    #1;
    reset_checks();
    rst = 1;
  endtask

  initial begin
    in_t s;
    m_held = 0;
    s = idle();
    s.valid = 1; s.q1 = 5'd2; s.cv = 1; s.ctag = 5'd2; s.cres = 32'h1234;
    apply(s);
    #2;
    reset_checks();
    @(posedge clk);
    #1;
    reset_checks();
    rst = 1;
    // ADD x3,x1,x2 with ready sources
    s = idle(); s.valid = 1; s.op = 6'd1; s.rd = 5'd3; s.v1 = 5; s.v2 = 7; s.rob_tag = 5'd9;
    step(s);
    step(idle());
    // rs1 pending on tag 3, CDB delivers it in the accept cycle
    s = idle(); s.valid = 1; s.op = 6'd2; s.rd = 5'd4; s.q1 = 5'd3; s.v2 = 11; s.rob_tag = 5'd10;
    s.cv = 1; s.ctag = 5'd3; s.cres = 32'h2A;
    step(s);
    step(idle());
    // RS full for 4 cycles, Q2 = 5 woken in the second stalled cycle
    s = idle(); s.valid = 1; s.op = 6'd3; s.rd = 5'd5; s.q2 = 5'd5; s.v1 = 1; s.rob_tag = 5'd11;
    step(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.valid = 1; s.rd = 5'd6; s.rob_tag = 5'd12; s.rs_full = 1;
      if (i == 1) begin s.cv = 1; s.ctag = 5'd5; s.cres = 9; end
      step(s);
    end
    step(idle());
    step(idle());
    // wake-up coincides with the cycle full drops: bypass
    s = idle(); s.valid = 1; s.op = 6'd4; s.q1 = 5'd6; s.q2 = 5'd7; s.rob_tag = 5'd13;
    step(s);
    s = idle(); s.rs_full = 1; step(s);
    s = idle(); s.cv = 1; s.ctag = 5'd6; s.cres = 32'h55; step(s);
    // ROB full: no accept, held load/store still issues
    s = idle(); s.valid = 1; s.op = 6'd5; s.is_ls = 1; s.rd = 5'd8; s.rob_tag = 5'd14; s.v1 = 3;
    step(s);
    s = idle(); s.valid = 1; s.rob_full = 1; s.lsb_full = 1; s.rd = 5'd9; step(s);
    s = idle(); s.valid = 1; s.rob_full = 1; s.rd = 5'd9; step(s);
    step(idle());
    // rollback while held, then back-to-back accepts
    s = idle(); s.valid = 1; s.op = 6'd6; s.rd = 5'd1; s.rob_tag = 5'd15; step(s);
    s = idle(); s.rs_full = 1; s.rb = 1; s.valid = 1; step(s);
    step(idle());
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.valid = 1; s.op = 6'(7 + i); s.rd = 5'(i + 1); s.rob_tag = 5'(16 + i); s.v1 = i;
      step(s);
    end
    step(idle());
    // reset in the middle of a stall drops the slot
    s = idle(); s.valid = 1; s.op = 6'd12; s.rd = 5'd2; s.rob_tag = 5'd20; step(s);
    s = idle(); s.rs_full = 1; step(s);
    s = idle(); s.valid = 1; reset_mid(s);
    step(idle());
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.valid = 1; s.op = 6'(20 + i); s.rd = 5'(10 + i); s.rob_tag = 5'(21 + i);
      step(s);
    end
    step(idle());
    for (int i = 0; i < 3000; i++) begin
      if (i % 997 == 500) reset_mid(rnd_in());
      else step(rnd_in());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
